// File: rtl/mux_serial_seq.sv
// mux_serial_seq: drives an 8:1 mux as a parallel-in/serial-out shifter.
// Accepts a word on valid/ready, holds it on mux_in, walks mux_sel through
// all positions and registers the sampled mux_out into a serial stream with
// backpressure and a last-bit marker.
// Optional build macro MUX_SERIAL_PARITY_EN appends an even-parity bit
// after bit 7 (ser_last then marks the parity bit).
module mux_serial_seq #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = 3,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] mux_in,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_out,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [SEL_W-1:0] CNT_MAX = SEL_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] cnt;
    logic             accept;
    logic             adv;
    logic             frame_end;
    logic             cnt_at_max;

    // Select order: ascending count or its mirror.
    function automatic logic [SEL_W-1:0] map_sel(input logic [SEL_W-1:0] c);
        return MSB_FIRST ? (CNT_MAX - c) : c;
    endfunction

    assign accept     = (state == IDLE) && din_valid;
    assign adv        = (state == SHIFT) && (!ser_valid || ser_ready);
    assign cnt_at_max = (cnt == CNT_MAX);

`ifdef MUX_SERIAL_PARITY_EN
    logic par_phase;  // set while the parity bit is the next one to emit
    logic par_acc;    // running XOR of the sampled data bits
    assign frame_end = adv && par_phase;
`else
    assign frame_end = adv && cnt_at_max;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: one accept opens a frame, the final advance closes it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = SHIFT;
            SHIFT:   if (frame_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM-level outputs.
    always_comb begin
        din_ready = (state == IDLE);
        busy      = (state == SHIFT) || ser_valid;
    end

    // Datapath: word hold, bit counter/select, and the serial output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_in    <= '0;
            mux_sel   <= '0;
            cnt       <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
`ifdef MUX_SERIAL_PARITY_EN
            par_phase <= 1'b0;
            par_acc   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                mux_in  <= din;
                cnt     <= '0;
                mux_sel <= map_sel('0);
`ifdef MUX_SERIAL_PARITY_EN
                par_phase <= 1'b0;
                par_acc   <= 1'b0;
`endif
            end
            if (adv) begin
                ser_valid <= 1'b1;
`ifdef MUX_SERIAL_PARITY_EN
                if (par_phase) begin
                    ser_bit   <= par_acc;
                    ser_last  <= 1'b1;
                    par_phase <= 1'b0;
                    cnt       <= '0;
                    mux_sel   <= map_sel('0);
                end else begin
                    ser_bit  <= mux_out;
                    ser_last <= 1'b0;
                    par_acc  <= par_acc ^ mux_out;
                    // On bit 7 the count and select stay put for the parity cycle.
                    if (cnt_at_max) begin
                        par_phase <= 1'b1;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        mux_sel <= map_sel(cnt + 1'b1);
                    end
                end
`else
                ser_bit  <= mux_out;
                ser_last <= cnt_at_max;
                if (cnt_at_max) begin
                    cnt     <= '0;
                    mux_sel <= map_sel('0);
                end else begin
                    cnt     <= cnt + 1'b1;
                    mux_sel <= map_sel(cnt + 1'b1);
                end
`endif
            end else if (ser_valid && ser_ready) begin
                // Consumed with nothing new to load: output register empties.
                ser_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_serial_seq.sv
// Directed bench for mux_serial_seq: two instances (LSB-first and MSB-first)
// share stimulus, each driving its own behavioural 8:1 mux.
module tb_mux_serial_seq;

`ifdef MUX_SERIAL_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = PAR ? 9 : 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       ser_ready;

    logic       din_ready_a, ser_bit_a, ser_valid_a, ser_last_a, busy_a, mux_out_a;
    logic [7:0] mux_in_a;
    logic [2:0] mux_sel_a;
    logic       din_ready_b, ser_bit_b, ser_valid_b, ser_last_b, busy_b, mux_out_b;
    logic [7:0] mux_in_b;
    logic [2:0] mux_sel_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural mux models.
    assign mux_out_a = mux_in_a[mux_sel_a];
    assign mux_out_b = mux_in_b[mux_sel_b];

    mux_serial_seq #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_a), .mux_in(mux_in_a), .mux_sel(mux_sel_a),
        .mux_out(mux_out_a), .ser_bit(ser_bit_a), .ser_valid(ser_valid_a),
        .ser_last(ser_last_a), .ser_ready(ser_ready), .busy(busy_a)
    );

    mux_serial_seq #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_b), .mux_in(mux_in_b), .mux_sel(mux_sel_b),
        .mux_out(mux_out_b), .ser_bit(ser_bit_b), .ser_valid(ser_valid_b),
        .ser_last(ser_last_b), .ser_ready(ser_ready), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle past the edge before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serialize one word with ser_ready high, optionally stalling 3 cycles
    // after bit stall_at has appeared on the output.
    task automatic run_frame(input logic [7:0] w, input int stall_at);
        din = w;
        din_valid = 1'b1;
        chk("accept_ready", 32'(din_ready_a), 32'd1);
        tick();
        din_valid = 1'b0;
        chk("mux_in_a", 32'(mux_in_a), 32'(w));
        for (int i = 0; i < 8; i++) begin
            chk("sel_a", 32'(mux_sel_a), 32'(i));
            chk("sel_b", 32'(mux_sel_b), 32'(7 - i));
            chk("ready_low", 32'(din_ready_a), 32'd0);
            chk("busy_a", 32'(busy_a), 32'd1);
            tick();
            chk("valid_a", 32'(ser_valid_a), 32'd1);
            chk("bit_a", 32'(ser_bit_a), 32'(w[i]));
            chk("bit_b", 32'(ser_bit_b), 32'(w[7 - i]));
            chk("last_a", 32'(ser_last_a), 32'(i == 7 && !PAR));
            chk("last_b", 32'(ser_last_b), 32'(i == 7 && !PAR));
            if (i == stall_at) begin
                ser_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("stall_valid", 32'(ser_valid_a), 32'd1);
                    chk("stall_bit_a", 32'(ser_bit_a), 32'(w[i]));
                    chk("stall_bit_b", 32'(ser_bit_b), 32'(w[7 - i]));
                    chk("stall_sel_a", 32'(mux_sel_a), 32'(i + 1));
                    chk("stall_sel_b", 32'(mux_sel_b), 32'(6 - i));
                end
                ser_ready = 1'b1;
            end
        end
        if (PAR) begin
            chk("par_sel_a", 32'(mux_sel_a), 32'd7);
            chk("par_sel_b", 32'(mux_sel_b), 32'd0);
            tick();
            chk("par_valid", 32'(ser_valid_a), 32'd1);
            chk("par_bit_a", 32'(ser_bit_a), 32'(^w));
            chk("par_bit_b", 32'(ser_bit_b), 32'(^w));
            chk("par_last", 32'(ser_last_a), 32'd1);
        end
        tick();
        chk("end_valid", 32'(ser_valid_a), 32'd0);
        chk("end_ready", 32'(din_ready_a), 32'd1);
        chk("end_busy", 32'(busy_a), 32'd0);
    endtask

    initial begin
        int vcnt, ones, lasts;
        rst_n = 1'b0;
        din = 8'h00;
        din_valid = 1'b0;
        ser_ready = 1'b1;

        // Reset state.
        #3;
        chk("rst_ready", 32'(din_ready_a), 32'd1);
        chk("rst_valid", 32'(ser_valid_a), 32'd0);
        chk("rst_bit", 32'(ser_bit_a), 32'd0);
        chk("rst_last", 32'(ser_last_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_mux_in", 32'(mux_in_a), 32'd0);
        chk("rst_sel_a", 32'(mux_sel_a), 32'd0);
        chk("rst_sel_b", 32'(mux_sel_b), 32'd0);
        din_valid = 1'b1;
        din = 8'h5A;
        tick();
        chk("rst_no_accept", 32'(mux_in_a), 32'd0);
        din_valid = 1'b0;
        rst_n = 1'b1;

        // Idle for 10 cycles with no valid.
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_valid", 32'(ser_valid_a), 32'd0);
            chk("idle_busy", 32'(busy_a), 32'd0);
            chk("idle_ready", 32'(din_ready_a), 32'd1);
        end

        run_frame(8'hA5, -1);
        run_frame(8'h01, -1);
        run_frame(8'h3C, 2);
        run_frame(8'h07, -1);

        // Back-to-back FF then 00 with din_valid held high.
        din = 8'hFF;
        din_valid = 1'b1;
        tick();
        din = 8'h00;
        vcnt = 0; ones = 0; lasts = 0;
        for (int k = 1; k <= 2 * NB + 3; k++) begin
            tick();
            if (k == NB + 1) begin
                chk("bubble", 32'(ser_valid_a), 32'd0);
                din_valid = 1'b0;
            end
            if (ser_valid_a) begin
                vcnt++;
                if (ser_bit_a) ones++;
                if (ser_last_a) lasts++;
                chk("b2b_bit", 32'(ser_bit_a), 32'(k <= 8));
            end
        end
        chk("b2b_vcnt", 32'(vcnt), 32'(2 * NB));
        chk("b2b_ones", 32'(ones), 32'd8);
        chk("b2b_lasts", 32'(lasts), 32'd2);

        // Reset in the middle of a 0F frame.
        din = 8'h0F;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_bit", 32'(ser_bit_a), 32'(i < 4));
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ser_valid_a), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_ready", 32'(din_ready_a), 32'd1);
        chk("mid_rst_sel", 32'(mux_sel_a), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_valid", 32'(ser_valid_a), 32'd0);
        end
        run_frame(8'hF0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
